// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control FSM for a time-multiplexed single-MAC FIR.
// Accepts one sample, walks the tap mux and coefficient ROM across all taps,
// waits out the MAC pipeline, then holds the result until downstream takes it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a sample; delay line shifts on the handshake edge
// ST_MAC   | one accumulator update per cycle, tap k = 0 .. NTAPS-1
// ST_DRAIN | MAC pipeline flushing, MAC_LAT cycles
// ST_OUT   | result valid, held until m_ready_i
module fir_mac_sequencer #(
  parameter int NTAPS   = 8,
  parameter int MAC_LAT = 2,
  parameter int AW      = $clog2(NTAPS),
  parameter int FCW     = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  output logic           shift_en_o,
  output logic [AW-1:0]  tap_sel_o,
  output logic [AW-1:0]  coef_addr_o,
  output logic           acc_clr_o,
  output logic           acc_en_o,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic           busy_o,
  output logic [FCW-1:0] frame_cnt_o
);

  // Drain counter needs at least one bit even when the pipeline is 0 or 1 deep.
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [DW-1:0] D_LAST = DW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  k_q, k_d;
  logic [DW-1:0]  d_q, d_d;
  logic [FCW-1:0] fc_q, fc_d;

  // Next-state, tap/drain counters and completed-frame counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    fc_d    = fc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid_i) begin
          state_d = ST_MAC;
          k_d     = '0;
        end
      end
      ST_MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          d_d     = '0;
          state_d = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (d_q == D_LAST) begin
          d_d     = '0;
          state_d = ST_OUT;
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready_i) begin
          fc_d    = fc_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      d_q     <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
      fc_q    <= fc_d;
    end
  end

  // Output decode from the registered state; everything is forced low during reset.
  always_comb begin
    s_ready_o = 1'b0;
    acc_en_o  = 1'b0;
    acc_clr_o = 1'b0;
    m_valid_o = 1'b0;
    busy_o    = 1'b0;
    tap_sel_o = '0;
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: s_ready_o = 1'b1;
        ST_MAC: begin
          acc_en_o  = 1'b1;
          tap_sel_o = k_q;
          acc_clr_o = (k_q == '0);
        end
        ST_OUT:  m_valid_o = 1'b1;
        default: ;
      endcase
      busy_o = (state_q != ST_IDLE);
    end
    // Combinational so the delay line captures on the same edge as the handshake.
    shift_en_o  = s_valid_i & s_ready_o;
    coef_addr_o = tap_sel_o;
  end

  assign frame_cnt_o = fc_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: scoreboard of accepted frames checked
// cycle by cycle against a frame-level timing model, plus a small second
// instance with no MAC pipeline.
module tb_fir_mac_sequencer;

  localparam int NT  = 4;
  localparam int ML  = 2;
  localparam int AW  = 2;
  localparam int FCW = 2;
  localparam int LAT = 1 + NT + ML;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  logic s_ready, shift_en, acc_clr, acc_en, m_valid, busy;
  logic [AW-1:0] tap_sel, coef_addr;
  logic [FCW-1:0] frame_cnt;

  fir_mac_sequencer #(.NTAPS(NT), .MAC_LAT(ML), .AW(AW), .FCW(FCW)) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .shift_en_o(shift_en), .tap_sel_o(tap_sel), .coef_addr_o(coef_addr),
    .acc_clr_o(acc_clr), .acc_en_o(acc_en), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  logic s_valid1 = 1'b0;
  logic s_ready1, shift_en1, acc_clr1, acc_en1, m_valid1, busy1;
  logic [0:0] tap_sel1, coef_addr1;
  logic [15:0] frame_cnt1;

  fir_mac_sequencer #(.NTAPS(2), .MAC_LAT(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid1), .s_ready_o(s_ready1),
    .shift_en_o(shift_en1), .tap_sel_o(tap_sel1), .coef_addr_o(coef_addr1),
    .acc_clr_o(acc_clr1), .acc_en_o(acc_en1), .m_valid_o(m_valid1),
    .m_ready_i(1'b1), .busy_o(busy1), .frame_cnt_o(frame_cnt1)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             acc;
    logic [FCW-1:0] fc;
  } frame_t;
  frame_t exp_q[$];

  logic [FCW-1:0] pushed_fc = '0;
  logic [FCW-1:0] fc_model  = '0;
  logic [FCW-1:0] fc_obs[$];
  bit last_hs = 0;

  // Monitor: compares every non-reset cycle against the frame at the head of the queue.
  bit inf, win, done_now, pop_pending = 0;
  int a, exp_tap;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {26'd0, s_ready, shift_en, acc_clr, acc_en, m_valid, busy}, 0);
      chk("rst_tap", tap_sel, 0);
      fc_model    = '0;
      pop_pending = 0;
    end else begin
      if (pop_pending) begin
        fc_obs.push_back(frame_cnt);
        pop_pending = 0;
      end
      inf      = (exp_q.size() != 0);
      a        = inf ? exp_q[0].acc : 0;
      win      = inf && (cyc >= a + 1) && (cyc <= a + NT);
      exp_tap  = win ? (cyc - a - 1) : 0;
      done_now = inf && (cyc >= a + LAT);
      chk("s_ready", s_ready, !inf);
      chk("shift_en", shift_en, s_valid && !inf);
      chk("busy", busy, inf);
      chk("acc_en", acc_en, win);
      chk("acc_clr", acc_clr, win && (cyc == a + 1));
      chk("tap_sel", tap_sel, exp_tap);
      chk("coef_addr", coef_addr, exp_tap);
      chk("m_valid", m_valid, done_now);
      chk("frame_cnt", frame_cnt, fc_model);
      if (done_now && m_ready) begin
        fc_model = exp_q[0].fc;
        void'(exp_q.pop_front());
        pop_pending = 1;
      end
    end
  end

  // One clock of stimulus; an accepted sample pushes its expected frame.
  task automatic step();
    bit hs;
    int ac;
    @(negedge clk);
    hs = !rst && s_valid && s_ready;
    ac = cyc;
    @(posedge clk);
    #1;
    last_hs = hs;
    if (hs) begin
      pushed_fc = pushed_fc + 1'b1;
      exp_q.push_back('{ac, pushed_fc});
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    pushed_fc = '0;
    run(n);
    rst = 1'b0;
  endtask

  int exp_wrap[5] = '{1, 2, 3, 0, 1};

  initial begin
    apply_reset(2);

    // basic frame
    m_ready = 1'b1; s_valid = 1'b1; step();
    s_valid = 1'b0; run(10);

    // backpressure: output held, second sample held by source until after OUT
    m_ready = 1'b0; s_valid = 1'b1; step();
    s_valid = 1'b0; run(8);
    s_valid = 1'b1; run(3);
    m_ready = 1'b1; step();
    step();
    chk("bp_accept", last_hs, 1);
    s_valid = 1'b0; run(12);

    // streaming
    s_valid = 1'b1; run(24);
    s_valid = 1'b0; run(10);

    // reset mid-frame
    s_valid = 1'b1; step();
    s_valid = 1'b0; run(2);
    apply_reset(1);
    run(12);

    // frame counter wrap
    fc_obs.delete();
    s_valid = 1'b1; run(40);
    s_valid = 1'b0; run(10);
    chk("wrap_n", fc_obs.size(), 5);
    for (int i = 0; i < 5 && i < fc_obs.size(); i++) chk("wrap_seq", fc_obs[i], exp_wrap[i]);

    // randomized traffic with occasional resets
    repeat (3000) begin
      if (!s_valid || last_hs) s_valid = ($urandom_range(0, 2) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) apply_reset($urandom_range(1, 2));
      else step();
    end
    s_valid = 1'b0; m_ready = 1'b1; run(20);

    // second instance: NTAPS=2, no pipeline drain
    s_valid1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l0_shift", shift_en1, i == 0);
      chk("l0_s_ready", s_ready1, (i == 0) || (i >= 4));
      chk("l0_acc_en", acc_en1, (i == 1) || (i == 2));
      chk("l0_acc_clr", acc_clr1, i == 1);
      chk("l0_tap", tap_sel1, i == 2);
      chk("l0_m_valid", m_valid1, i == 3);
      chk("l0_busy", busy1, (i >= 1) && (i <= 3));
      @(posedge clk);
      #1;
      s_valid1 = 1'b0;
    end
    chk("l0_frame_cnt", frame_cnt1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed control FSM for a single-MAC FIR filter.
- Sequences the tap delay line, built as a chain of W-bit enable flops, and walks the tap mux and coefficient ROM address across NTAPS taps.
- Controls accumulator clear/enable, waits out the MAC pipeline, and presents the result with a valid/ready handshake.
- Sits between the sample source and the datapath (delay line + tap mux + coefficient ROM + MAC).

Parameters:
- NTAPS, 8, number of filter taps; must be >= 2.
- MAC_LAT, 2, pipeline cycles from acc_en_o to accumulator result valid; must be >= 0.
- AW, $clog2(NTAPS), width of tap_sel_o and coef_addr_o.
- FCW, 16, width of frame_cnt_o.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- s_valid_i  input  1  new input sample available.
- s_ready_o  output  1  sequencer can accept a sample.
- shift_en_o  output  1  enable to every delay-line flop; shifts the sample in.
- tap_sel_o  output  AW  tap mux select.
- coef_addr_o  output  AW  coefficient ROM address; always equals tap_sel_o.
- acc_clr_o  output  1  accumulator loads the product instead of adding it.
- acc_en_o  output  1  accumulator update enable.
- m_valid_o  output  1  filter output valid.
- m_ready_i  input  1  downstream accepts the output.
- busy_o  output  1  high in any state except IDLE.
- frame_cnt_o  output  FCW  count of completed output handshakes.

Behaviour:
- States: IDLE, MAC, DRAIN, OUT. Internal tap counter k (AW bits) and drain counter d.
- Reset: rst_i sampled at the clock edge.
  - Forces state IDLE, k=0, d=0, frame_cnt_o=0.
  - While rst_i=1: s_ready_o, shift_en_o, acc_clr_o, acc_en_o, m_valid_o and busy_o are all 0, and tap_sel_o=0.
  - A reset mid-frame abandons the frame; no m_valid_o is produced for it.
- IDLE:
  - s_ready_o=1 (gated by ~rst_i).
  - shift_en_o = s_valid_i & s_ready_o, combinational, so the delay line captures on the handshake edge.
  - On handshake: go to MAC with k=0. Otherwise stay.
- MAC:
  - acc_en_o=1 and tap_sel_o=coef_addr_o=k.
  - acc_clr_o=1 only when k=0.
  - k increments each cycle.
  - When k=NTAPS-1: go to DRAIN with d=0, or to OUT if MAC_LAT=0. k returns to 0.
  - Exactly NTAPS acc_en_o cycles per frame.
- DRAIN: acc_en_o=0. d increments each cycle; on d=MAC_LAT-1, go to OUT.
- OUT:
  - m_valid_o=1, held with no dependence on m_ready_i until handshake.
  - On m_valid_o & m_ready_i: frame_cnt_o increments, wrapping 2^FCW-1 -> 0, and state returns to IDLE.
- Outside IDLE: s_ready_o=0 and shift_en_o=0. A sample offered during MAC/DRAIN/OUT is held by the source, never dropped or shifted.
- tap_sel_o holds 0 outside MAC.
- All outputs are 0 outside their active states.
- busy_o = (state != IDLE).
- Latency, handshake edge to m_valid_o: 1 + NTAPS + MAC_LAT cycles.
- Minimum sample period with m_ready_i=1: NTAPS + MAC_LAT + 2 cycles. No back-to-back acceptance.
- s_valid_i in the same cycle as the output handshake in OUT is not accepted; it is accepted in the following IDLE cycle.

Test Plan:
- Basic frame, NTAPS=4, MAC_LAT=2, m_ready_i=1, s_valid_i pulsed at cycle 0 -> shift_en_o=1 at cycle 0 only; acc_en_o=1 at cycles 1-4 with tap_sel_o=0,1,2,3; acc_clr_o=1 at cycle 1 only; m_valid_o=1 at cycle 7; IDLE at cycle 8; frame_cnt_o=1.
- Backpressure: same stimulus, m_ready_i=0 until cycle 12 -> m_valid_o held 1 for cycles 7-12; s_ready_o=0 throughout; s_valid_i held high from cycle 9 is accepted at cycle 13 (shift_en_o=1 there).
- Streaming, s_valid_i held 1 with m_ready_i=1 -> handshakes at cycles 0, 8, 16; each frame shows exactly 4 acc_en_o and 1 acc_clr_o.
- MAC_LAT=0, NTAPS=2 -> acc_en_o at cycles 1-2, m_valid_o at cycle 3, no DRAIN cycle.
- Reset mid-frame: rst_i=1 at cycle 3 of a frame -> cycle 4 IDLE with all controls 0 and s_ready_o=1; no m_valid_o; frame_cnt_o=0.
- Wrap: FCW=2, 5 completed frames -> frame_cnt_o sequence 1,2,3,0,1.
